// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: accepts one upstream request at a time,
// performs alignment checking, issues a single memory address/data beat and
// returns an extended load result or a completion/error pulse.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        Men,
  output logic        Mwout,
  output logic [63:0] Maddr,
  output logic [31:0] Mlen,
  output logic [63:0] MdataOut,
  output logic        addr_valid,
  input  logic        addr_ready,
  output logic        data_ready,
  input  logic        data_valid,
  input  logic [63:0] MdataIn
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_RD = 3'd1,
    ADDR_WR = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [63:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [63:0] wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        men_q, men_d;
  logic        mw_q, mw_d;
  logic [63:0] maddr_q, maddr_d;
  logic [31:0] mlen_q, mlen_d;
  logic [63:0] mdata_out_q, mdata_out_d;
  logic        addr_valid_q, addr_valid_d;
  logic        data_ready_q, data_ready_d;

  logic        accept;
  logic        misaligned;
  logic        timeout_hit;
  logic [63:0] shifted;
  logic [63:0] ld_ext;

  assign accept      = req_valid && (state_q == IDLE);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Alignment check on the incoming request: low address bits must be zero for the size
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  // Request field capture on acceptance
  always_comb begin
    addr_d  = accept ? req_addr     : addr_q;
    size_d  = accept ? req_size     : size_q;
    we_d    = accept ? req_we       : we_q;
    uns_d   = accept ? req_unsigned : uns_q;
    wdata_d = accept ? req_wdata    : wdata_q;
  end

  // Pick the addressed lane out of the doubleword and extend it to 64 bits
  always_comb begin
    shifted = MdataIn >> {addr_q[2:0], 3'b000};
    ld_ext  = shifted;
    case (size_q)
      2'd0:    ld_ext = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1:    ld_ext = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    ld_ext = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: ld_ext = shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; data_valid wins over a coincident timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned)  state_d = RESP;
          else if (req_we) state_d = ADDR_WR;
          else             state_d = ADDR_RD;
        end
      end
      ADDR_RD: if (addr_ready) state_d = RD_WAIT;
      ADDR_WR: if (addr_ready) state_d = RESP;
      RD_WAIT: begin
        if (data_valid)       state_d = RESP;
        else if (timeout_hit) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so every port comes straight from a flop
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    men_d        = (state_d == ADDR_RD) || (state_d == ADDR_WR);
    mw_d         = (state_d == ADDR_WR);
    addr_valid_d = men_d;
    data_ready_d = (state_d == ADDR_WR) || (state_d == RD_WAIT);
    maddr_d      = men_d ? addr_d : 64'd0;
    mlen_d       = men_d ? (32'd1 << size_d) : 32'd0;
    mdata_out_d  = mw_d ? wdata_d : 64'd0;
    resp_valid_d = (state_d == RESP);
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept && misaligned) begin
          resp_rdata_d = 64'd0;
          resp_err_d   = 1'b1;
        end
      end
      ADDR_WR: begin
        if (addr_ready) begin
          resp_rdata_d = 64'd0;
          resp_err_d   = 1'b0;
        end
      end
      RD_WAIT: begin
        if (data_valid) begin
          resp_rdata_d = ld_ext;
          resp_err_d   = 1'b0;
        end else if (timeout_hit) begin
          resp_rdata_d = 64'd0;
          resp_err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Latched request fields and RD_WAIT cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 64'd0;
      size_q  <= 2'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= 64'd0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      if (state_q == RD_WAIT && !data_valid && !timeout_hit) cnt_q <= cnt_q + CNT_W'(1);
      else                                                   cnt_q <= '0;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
      men_q        <= 1'b0;
      mw_q         <= 1'b0;
      maddr_q      <= 64'd0;
      mlen_q       <= 32'd0;
      mdata_out_q  <= 64'd0;
      addr_valid_q <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      men_q        <= men_d;
      mw_q         <= mw_d;
      maddr_q      <= maddr_d;
      mlen_q       <= mlen_d;
      mdata_out_q  <= mdata_out_d;
      addr_valid_q <= addr_valid_d;
      data_ready_q <= data_ready_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign Men        = men_q;
  assign Mwout      = mw_q;
  assign Maddr      = maddr_q;
  assign Mlen       = mlen_q;
  assign MdataOut   = mdata_out_q;
  assign addr_valid = addr_valid_q;
  assign data_ready = data_ready_q;

  // we_q is retained for completeness of the captured request; routing uses state
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl using a response scoreboard.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        Men;
  logic        Mwout;
  logic [63:0] Maddr;
  logic [31:0] Mlen;
  logic [63:0] MdataOut;
  logic        addr_valid;
  logic        addr_ready;
  logic        data_ready;
  logic        data_valid;
  logic [63:0] MdataIn;

  logic dv_en;
  logic force_dv;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_fail;
  int   men_cnt;

  lsu_mem_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .Men(Men), .Mwout(Mwout), .Maddr(Maddr), .Mlen(Mlen), .MdataOut(MdataOut),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .data_ready(data_ready),
    .data_valid(data_valid), .MdataIn(MdataIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle memory: returns data in the first cycle the controller waits for it
  assign data_valid = force_dv | (dv_en & data_ready & ~Men);

  always @(posedge clk) if (Men) men_cnt <= men_cnt + 1;

  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [1:0] sz,
                                             input logic u, input logic [63:0] w);
    int n;
    int base;
    logic [63:0] v;
    n    = 1 << sz;
    base = int'(a[2:0]);
    v    = 64'd0;
    for (int i = 0; i < 8; i++)
      if (i < n && base + i < 8) v[8*i +: 8] = w[8*(base+i) +: 8];
    if (!u && n < 8 && v[8*n-1])
      for (int i = 0; i < 8; i++)
        if (i >= n) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic push_exp(input logic [63:0] rd, input logic err, input int lat);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    e.lat   = 8'(lat);
    sb.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [63:0] a, input logic [1:0] sz,
                       input logic u, input logic [63:0] wd);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = a;
    req_size     = sz;
    req_unsigned = u;
    req_wdata    = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int first, output int lat, output logic got);
    got = 1'b0;
    lat = 0;
    for (int i = first; i < first + 64 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        lat = i;
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
    n_cmp++;
    if ({resp_valid, resp_err, Men, Mwout, addr_valid, data_ready} !== 6'b0 ||
        resp_rdata !== 64'd0 || Maddr !== 64'd0 || Mlen !== 32'd0 || MdataOut !== 64'd0) begin
      n_fail++; $display("FAIL reset_outputs: got rv=%b err=%b men=%b mw=%b av=%b dr=%b want all 0",
                         resp_valid, resp_err, Men, Mwout, addr_valid, data_ready);
    end
  endtask

  task automatic test_load_b();
    int lat; logic got; exp_t e;
    MdataIn = 64'h0000_0000_F000_0000;
    push_exp(64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 3);
    issue(1'b0, 64'h8000_0003, 2'd0, 1'b0, 64'd0);
    wait_resp(1, lat, got);
    e = sb.pop_front();
    n_cmp++;
    if (!got || lat !== int'(e.lat)) begin
      n_fail++; $display("FAIL load_b_latency: got %0d (seen=%b) want %0d", lat, got, e.lat);
    end
    n_cmp++;
    if (resp_rdata !== e.rdata || resp_err !== e.err) begin
      n_fail++; $display("FAIL load_b_data: got %h/%b want %h/%b", resp_rdata, resp_err, e.rdata, e.err);
    end
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b0 || resp_rdata !== e.rdata) begin
      n_fail++; $display("FAIL load_b_pulse_hold: got rv=%b rd=%h want rv=0 rd=%h", resp_valid, resp_rdata, e.rdata);
    end
  endtask

  task automatic test_store_w();
    int lat; logic got; exp_t e;
    push_exp(64'd0, 1'b0, 2);
    issue(1'b1, 64'h8000_0004, 2'd2, 1'b0, 64'h1234_5678);
    @(negedge clk);
    n_cmp++;
    if ({Men, Mwout, addr_valid, data_ready} !== 4'b1111 || Mlen !== 32'd4) begin
      n_fail++; $display("FAIL store_ctrl: got men=%b mw=%b av=%b dr=%b len=%0d want 1111 len=4",
                         Men, Mwout, addr_valid, data_ready, Mlen);
    end
    n_cmp++;
    if (Maddr !== 64'h8000_0004 || MdataOut !== 64'h1234_5678) begin
      n_fail++; $display("FAIL store_addr_data: got %h/%h want 80000004/12345678", Maddr, MdataOut);
    end
    wait_resp(2, lat, got);
    e = sb.pop_front();
    n_cmp++;
    if (!got || lat !== int'(e.lat) || resp_err !== e.err) begin
      n_fail++; $display("FAIL store_resp: got lat=%0d seen=%b err=%b want lat=%0d err=%b", lat, got, resp_err, e.lat, e.err);
    end
    n_cmp++;
    if (Men !== 1'b0 || Mwout !== 1'b0 || data_ready !== 1'b0) begin
      n_fail++; $display("FAIL store_idle_mem: got men=%b mw=%b dr=%b want 000", Men, Mwout, data_ready);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic got; exp_t e; int men0;
    men0 = men_cnt;
    MdataIn = 64'hDEAD_BEEF_CAFE_F00D;
    push_exp(64'd0, 1'b1, 1);
    issue(1'b0, 64'h8000_0001, 2'd1, 1'b0, 64'd0);
    wait_resp(1, lat, got);
    e = sb.pop_front();
    n_cmp++;
    if (!got || lat !== int'(e.lat)) begin
      n_fail++; $display("FAIL misaligned_latency: got %0d seen=%b want %0d", lat, got, e.lat);
    end
    n_cmp++;
    if (resp_err !== e.err || resp_rdata !== e.rdata) begin
      n_fail++; $display("FAIL misaligned_resp: got %h/%b want %h/%b", resp_rdata, resp_err, e.rdata, e.err);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (men_cnt !== men0) begin
      n_fail++; $display("FAIL misaligned_no_mem: got %0d Men cycles want 0", men_cnt - men0);
    end
    n_cmp++;
    if (resp_err !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL misaligned_hold: got err=%b rv=%b want err=1 rv=0", resp_err, resp_valid);
    end
  endtask

  task automatic test_timeout();
    int lat; logic got; exp_t e;
    dv_en   = 1'b0;
    MdataIn = 64'hFFFF_FFFF_FFFF_FFFF;
    push_exp(64'd0, 1'b1, 18);
    issue(1'b0, 64'h8000_0008, 2'd3, 1'b0, 64'd0);
    wait_resp(1, lat, got);
    e = sb.pop_front();
    n_cmp++;
    if (!got || lat !== int'(e.lat)) begin
      n_fail++; $display("FAIL timeout_latency: got %0d seen=%b want %0d", lat, got, e.lat);
    end
    n_cmp++;
    if (resp_err !== e.err || resp_rdata !== e.rdata) begin
      n_fail++; $display("FAIL timeout_resp: got %h/%b want %h/%b", resp_rdata, resp_err, e.rdata, e.err);
    end
    dv_en = 1'b1;
  endtask

  task automatic test_timeout_tie();
    int lat; logic got; exp_t e;
    dv_en   = 1'b0;
    MdataIn = 64'h0000_0000_0000_8001;
    push_exp(model_load(64'h8000_0010, 2'd1, 1'b0, 64'h8001), 1'b0, 18);
    issue(1'b0, 64'h8000_0010, 2'd1, 1'b0, 64'd0);
    repeat (17) @(negedge clk);
    force_dv = 1'b1;
    wait_resp(18, lat, got);
    force_dv = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (!got || lat !== int'(e.lat)) begin
      n_fail++; $display("FAIL tie_latency: got %0d seen=%b want %0d", lat, got, e.lat);
    end
    n_cmp++;
    if (resp_err !== e.err || resp_rdata !== e.rdata) begin
      n_fail++; $display("FAIL tie_resp: got %h/%b want %h/%b", resp_rdata, resp_err, e.rdata, e.err);
    end
    dv_en = 1'b1;
  endtask

  task automatic test_backpressure();
    int lat; logic got; exp_t e; int bad;
    bad = 0;
    MdataIn = 64'h0123_4567_89AB_CDEF;
    addr_ready = 1'b0;
    push_exp(model_load(64'h8000_0024, 2'd2, 1'b1, 64'h0123_4567_89AB_CDEF), 1'b0, 6);
    issue(1'b0, 64'h8000_0024, 2'd2, 1'b1, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (addr_valid !== 1'b1 || Men !== 1'b1 || Maddr !== 64'h8000_0024 || Mlen !== 32'd4) bad++;
    end
    addr_ready = 1'b1;
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
    end
    wait_resp(5, lat, got);
    e = sb.pop_front();
    n_cmp++;
    if (!got || lat !== int'(e.lat)) begin
      n_fail++; $display("FAIL bp_latency: got %0d seen=%b want %0d", lat, got, e.lat);
    end
    n_cmp++;
    if (resp_err !== e.err || resp_rdata !== e.rdata) begin
      n_fail++; $display("FAIL bp_resp: got %h/%b want %h/%b", resp_rdata, resp_err, e.rdata, e.err);
    end
  endtask

  task automatic test_reset_rd_wait();
    int seen;
    seen  = 0;
    dv_en = 1'b0;
    issue(1'b0, 64'h8000_0030, 2'd3, 1'b0, 64'd0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (data_ready !== 1'b1 || Men !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_pre: got dr=%b men=%b want dr=1 men=0", data_ready, Men);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || {resp_valid, resp_err, Men, Mwout, addr_valid, data_ready} !== 6'b0) begin
      n_fail++; $display("FAIL rst_mid_immediate: got rr=%b rv=%b err=%b men=%b mw=%b av=%b dr=%b want 1/000000",
                         req_ready, resp_valid, resp_err, Men, Mwout, addr_valid, data_ready);
    end
    @(negedge clk);
    rst      = 1'b0;
    force_dv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    force_dv = 1'b0;
    dv_en    = 1'b1;
    n_cmp++;
    if (seen != 0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_no_resp: got %0d pulses rr=%b want 0 pulses rr=1", seen, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic got; exp_t e;
    logic [1:0] sz; logic [63:0] a; logic [63:0] w; logic u; logic we;
    for (int k = 0; k < 10; k++) begin
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      we = (k % 3 == 2);
      w  = {$urandom, $urandom};
      a  = 64'h8000_1000 | 64'($urandom_range(0, 255) << 3) |
           64'($urandom_range(0, 7) & ~((1 << sz) - 1));
      if (k == 7) a = a | 64'h7;
      if (k == 7 && sz == 2'd0) sz = 2'd2;
      MdataIn = w;
      if (k == 7)  push_exp(64'd0, 1'b1, 1);
      else if (we) push_exp(64'd0, 1'b0, 2);
      else         push_exp(model_load(a, sz, u, w), 1'b0, 3);
      issue(we, a, sz, u, w);
      wait_resp(1, lat, got);
      e = sb.pop_front();
      n_cmp++;
      if (!got || lat !== int'(e.lat) || resp_rdata !== e.rdata || resp_err !== e.err) begin
        n_fail++; $display("FAIL b2b_%0d: got lat=%0d seen=%b rd=%h err=%b want lat=%0d rd=%h err=%b",
                           k, lat, got, resp_rdata, resp_err, e.lat, e.rdata, e.err);
      end
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    men_cnt      = 0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 64'd0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 64'd0;
    addr_ready   = 1'b1;
    MdataIn      = 64'd0;
    dv_en        = 1'b1;
    force_dv     = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_load_b();
    test_store_w();
    test_misaligned();
    test_timeout();
    test_timeout_tie();
    test_backpressure();
    test_reset_rd_wait();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
